mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one registered N:1 multiplexer output channel between `N_REQ` requesters. Each cycle it picks at most one requesting source, steers its data through the select path into a single output register, and acknowledges the source. It sits between several producer blocks and one downstream consumer, replacing hand-driven `sel` lines on bare muxes with a fair, flow-controlled scheduler.

---
 rtl/mux_rr_arbiter_if.sv | 39 +++
 rtl/mux_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter_if
// Handshake bundle between N_REQ producers, the round-robin arbiter and one
// downstream consumer.
//   req       : per-requester valid
//   data      : flattened request words, requester k at [k*DATA_W +: DATA_W]
//   ack       : one-hot (or zero) accept back to the requesters
//   out_valid : output register holds a word
//   out_data  : registered selected word
//   out_src   : index of the requester that supplied out_data
//   out_ready : consumer accepts the word this cycle
// Modports:
//   slave  - the arbiter side
//   master - the requesters plus the consumer
// -----------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data;
    logic [N_REQ-1:0]        ack;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic [SRC_W-1:0]        out_src;
    logic                    out_ready;

    modport slave (
        input  req, data, out_ready,
        output ack, out_valid, out_data, out_src
    );

    modport master (
        output req, data, out_ready,
        input  ack, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter feeding one registered N:1 output channel. Each cycle
// the output register can load (empty, or draining this cycle), the first
// requesting source at or after the priority pointer is acked with zero
// latency, its word is captured into the output register, and the pointer
// moves to just past the winner.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : mux_rr_arbiter_if.slave (req/data/ack in, out_* channel out)
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);
    localparam int SRC_W  = $clog2(N_REQ);
    // One spare bit so ptr + offset cannot overflow before the modulo fold.
    localparam int CAND_W = SRC_W + 1;
    localparam logic [CAND_W-1:0] N_CAND = CAND_W'(N_REQ);
    localparam logic [SRC_W-1:0]  LAST   = SRC_W'(N_REQ - 1);

    logic [SRC_W-1:0]  ptr;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0]  out_src_q;

    logic              load;
    logic              found;
    logic [SRC_W-1:0]  grant_idx;
    logic [CAND_W-1:0] cand;
    logic [DATA_W-1:0] grant_data;
    logic [N_REQ-1:0]  ack_c;

    // The channel takes a word when empty or when the current word drains now.
    assign load = ~out_valid_q | bus.out_ready;

    // Scan from ptr upward, wrapping, and keep the first requester found.
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + CAND_W'(i);
            if (cand >= N_CAND) begin
                cand = cand - N_CAND;
            end
            if (!found && bus.req[cand[SRC_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[SRC_W-1:0];
            end
        end
    end

    // Select path: steer the winner's slice toward the output register.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == SRC_W'(k)) begin
                grant_data = bus.data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Ack is combinational so a free channel accepts in the same cycle;
    // held low during reset so no word is handed off and then lost.
    always_comb begin
        ack_c = '0;
        if (!rst && load && found) begin
            ack_c[grant_idx] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else if (load) begin
            if (found) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_src_q   <= grant_idx;
                ptr         <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            end else begin
                // Drained with nothing to replace it: data/src keep last word.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ack       = ack_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed walk through reset, round robin, skip/wrap, backpressure, idle
// bubble and reset mid-stall, followed by randomized requesters obeying the
// valid/ready protocol. A behavioural model (pointer, output word) predicts
// ack and the output channel every cycle.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    mux_rr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                m_ptr   = 0;
    bit                m_valid = 1'b0;
    logic [DATA_W-1:0] m_data  = '0;
    int                m_src   = 0;

    // Random requester state
    bit                pend  [N_REQ];
    logic [DATA_W-1:0] pdata [N_REQ];
    logic [N_REQ-1:0]  acked;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester at or after p, wrapping; -1 when nobody requests.
    function automatic int winner(input logic [N_REQ-1:0] r, input int p);
        for (int i = 0; i < N_REQ; i++) begin
            if (r[(p + i) % N_REQ]) return (p + i) % N_REQ;
        end
        return -1;
    endfunction

    // Called at a falling edge with inputs already driven. Checks the DUT
    // against the model, crosses one rising edge, advances the model, and
    // returns at the next falling edge.
    task automatic cycle(input string tag, output logic [N_REQ-1:0] ack_exp);
        int                w;
        bit                ld;
        logic [DATA_W-1:0] wd;
        logic [N_REQ-1:0]  ea;
        #1;
        ld = !m_valid || (bus.out_ready === 1'b1);
        w  = winner(bus.req, m_ptr);
        ea = '0;
        if (rst !== 1'b1 && ld && w >= 0) ea[w] = 1'b1;
        check($sformatf("%s.ack", tag),       32'(bus.ack),       32'(ea));
        check($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'(m_valid));
        check($sformatf("%s.out_data", tag),  32'(bus.out_data),  32'(m_data));
        check($sformatf("%s.out_src", tag),   32'(bus.out_src),   32'(m_src));
        check($sformatf("%s.ptr", tag),       32'(dut.ptr),       32'(m_ptr));
        wd = (w >= 0) ? bus.data[w*DATA_W +: DATA_W] : '0;
        ack_exp = ea;
        @(posedge clk);
        if (rst === 1'b1) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
        end else if (ld) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = wd;
                m_src   = w;
                m_ptr   = (w + 1) % N_REQ;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // ---- Reset with everybody requesting ----
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.data      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cycle("reset0", acked);
        cycle("reset1", acked);

        // ---- Round robin: 0,1,2,3,0,1 ----
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle("rr", acked);
            check("rr.src_seq",  32'(bus.out_src),  32'(k % 4));
            check("rr.data_seq", 32'(bus.out_data), 32'(8'hA0 + (k % 4)));
        end
        cycle("rr_extra", acked);                 // grants 2, ptr -> 3
        check("rr_extra.src", 32'(bus.out_src), 32'd2);

        // ---- Skip and wrap ----
        bus.req = 4'b0101;
        cycle("skip0", acked);
        check("skip0.src", 32'(bus.out_src), 32'd0);
        check("skip0.ptr", 32'(dut.ptr),     32'd1);
        cycle("skip1", acked);
        check("skip1.src", 32'(bus.out_src), 32'd2);
        check("skip1.ptr", 32'(dut.ptr),     32'd3);

        // ---- Backpressure ----
        bus.req  = 4'b0010;
        bus.data = {8'hA3, 8'hA2, 8'h55, 8'hA0};
        cycle("bp_load", acked);
        bus.req       = 4'b1111;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("bp_stall", acked);
            check("bp_stall.data",  32'(bus.out_data),  32'h55);
            check("bp_stall.valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release.ack", 32'(bus.ack), 32'b0100);
        cycle("bp_release", acked);

        // ---- Idle bubble ----
        bus.req  = 4'b1000;
        bus.data = {8'h33, 8'hA2, 8'h55, 8'hA0};
        cycle("idle_load", acked);
        check("idle_load.valid", 32'(bus.out_valid), 32'd1);
        check("idle_load.src",   32'(bus.out_src),   32'd3);
        bus.req = 4'b0000;
        cycle("idle_gap", acked);
        check("idle_gap.valid", 32'(bus.out_valid), 32'd0);
        check("idle_gap.data",  32'(bus.out_data),  32'h33);
        check("idle_gap.src",   32'(bus.out_src),   32'd3);
        bus.req = 4'b0001;
        cycle("idle_next", acked);
        check("idle_next.src",   32'(bus.out_src),   32'd0);
        check("idle_next.valid", 32'(bus.out_valid), 32'd1);

        // ---- Reset mid-stall ----
        bus.req       = 4'b1111;
        bus.out_ready = 1'b0;
        cycle("mid_stall", acked);
        rst = 1'b1;
        cycle("mid_rst", acked);
        check("mid_rst.valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst.ptr",   32'(dut.ptr),       32'd0);
        rst           = 1'b0;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b1;
        cycle("post_rst", acked);
        check("post_rst.valid", 32'(bus.out_valid), 32'd0);

        // ---- Randomized requesters under random backpressure ----
        for (int k = 0; k < N_REQ; k++) begin
            pend[k]  = 1'b0;
            pdata[k] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k]  = 1'b1;
                    pdata[k] = DATA_W'($urandom);
                end
                bus.req[k]                 = pend[k];
                bus.data[k*DATA_W +: DATA_W] = pdata[k];
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 99) == 0);
            cycle("rand", acked);
            for (int k = 0; k < N_REQ; k++) begin
                if (acked[k]) pend[k] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
